// File: rtl/wallace_acc.sv
// wallace_acc: frame accumulator behind the 6x6 Wallace multiplier.
// Sums COUNT unsigned products per frame and presents each total on a
// valid/ready port. It flags carry-out per frame and sticky product drops.
// Optional build macro: SATURATE_EN clamps the total to 2^ACC_W-1 on carry.
// Without it the total wraps and acc_ovf still reports the carry.
module wallace_acc #(
  parameter int PROD_W = 13,
  parameter int ACC_W  = 16,
  parameter int COUNT  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              prod_valid,
  input  logic [PROD_W-1:0] prod,
  output logic              in_ready,
  output logic              acc_valid,
  input  logic              acc_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic              acc_ovf,
  output logic              drop_err,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  localparam int CW = $clog2(COUNT + 1);
  localparam logic [CW-1:0] LAST = CW'(COUNT - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  state_t            state, state_nxt, first_st;
  logic [ACC_W-1:0]  acc, acc_nxt;
  logic              ovf, ovf_nxt;
  logic [CW-1:0]     cnt;
  logic              accept;
  logic [ACC_W:0]    sum;

  // The multiplier cannot stall, so in_ready only gates what gets counted.
  assign in_ready = (state != HOLD) || acc_ready;
  assign accept   = prod_valid && in_ready;
  // A one-product frame completes on its first product.
  assign first_st = (COUNT == 1) ? HOLD : ACCUM;
  assign sum      = {1'b0, acc} + (ACC_W + 1)'(prod);

  // Running-sum update; bit ACC_W of the sum is the carry out.
  always_comb begin
    ovf_nxt = ovf | sum[ACC_W];
`ifdef SATURATE_EN
    // Once a frame has carried it stays pinned at full scale.
    acc_nxt = ovf_nxt ? '1 : sum[ACC_W-1:0];
`else
    acc_nxt = sum[ACC_W-1:0];
`endif
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; clear aborts the frame from any state.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (accept) state_nxt = first_st;
      ACCUM: if (accept && cnt == LAST) state_nxt = HOLD;
      HOLD:  if (acc_ready) state_nxt = prod_valid ? first_st : IDLE;
      default: state_nxt = IDLE;
    endcase
    if (clear) state_nxt = IDLE;
  end

  // Datapath: sum, carry flag, product counter and sticky drop flag.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      acc      <= '0;
      ovf      <= 1'b0;
      cnt      <= '0;
      drop_err <= 1'b0;
    end else begin
      if (prod_valid && !in_ready) drop_err <= 1'b1;
      if (accept) begin
        if (state == ACCUM) begin
          acc <= acc_nxt;
          ovf <= ovf_nxt;
          cnt <= cnt + ONE;
        end else begin
          // First product of a frame, from IDLE or on the HOLD handshake.
          acc <= ACC_W'(prod);
          ovf <= 1'b0;
          cnt <= ONE;
        end
      end
    end
  end

  // Outputs decoded from state; acc and ovf are frozen while in HOLD.
  always_comb begin
    acc_valid = (state == HOLD);
    busy      = (state == ACCUM);
    acc_out   = acc;
    acc_ovf   = ovf;
  end

endmodule

// File: tb/tb_wallace_acc.sv
// Testbench for wallace_acc. It runs directed frame scenarios, then random
// traffic checked every cycle against a frame-level reference model.
// The DUT is built with ACC_W=14 so that overflow is reachable.
module tb_wallace_acc;
  localparam int PROD_W = 13;
  localparam int ACC_W  = 14;
  localparam int COUNT  = 8;
  localparam int MAXV   = (1 << ACC_W) - 1;

  logic clk = 1'b0;
  logic rst_n, clear, prod_valid, acc_ready;
  logic [PROD_W-1:0] prod;
  logic in_ready, acc_valid, acc_ovf, drop_err, busy;
  logic [ACC_W-1:0] acc_out;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: accepted products of the open frame plus the held result.
  int m_n, m_sum, m_tot;
  bit m_hold, m_ovf, m_drop;

  wallace_acc #(.PROD_W(PROD_W), .ACC_W(ACC_W), .COUNT(COUNT)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .prod_valid(prod_valid),
    .prod(prod), .in_ready(in_ready), .acc_valid(acc_valid),
    .acc_ready(acc_ready), .acc_out(acc_out), .acc_ovf(acc_ovf),
    .drop_err(drop_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_n = 0; m_sum = 0; m_tot = 0; m_hold = 0; m_ovf = 0; m_drop = 0;
  endtask

  // Apply one cycle of inputs: check outputs before the edge, then advance the model.
  task automatic step(input bit pv, input int p, input bit ar, input bit cl = 0, input bit rs = 1);
    bit rdy;
    prod_valid = pv; prod = PROD_W'(p); acc_ready = ar; clear = cl; rst_n = rs;
    #1;
    rdy = !m_hold || ar;
    check("in_ready", in_ready, rdy);
    check("acc_valid", acc_valid, m_hold);
    check("busy", busy, m_n > 0);
    check("drop_err", drop_err, m_drop);
    if (m_hold) begin
      check("acc_out", acc_out, m_tot);
      check("acc_ovf", acc_ovf, m_ovf);
    end
    @(posedge clk);
    if (!rs || cl) model_reset();
    else begin
      if (pv && !rdy) m_drop = 1;
      if (m_hold && ar) m_hold = 0;
      if (pv && rdy) begin
        m_sum += p; m_n++;
        if (m_n == COUNT) begin
          m_hold = 1;
          m_ovf  = (m_sum > MAXV);
`ifdef SATURATE_EN
          m_tot  = m_ovf ? MAXV : m_sum;
`else
          m_tot  = m_sum % (MAXV + 1);
`endif
          m_n = 0; m_sum = 0;
        end
      end
    end
    @(negedge clk);
  endtask

  initial begin
    int exp_ovf_out;
    rst_n = 1'b0; clear = 1'b0; prod_valid = 1'b0; acc_ready = 1'b0; prod = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_valid", acc_valid, 0);
    check("rst_out", acc_out, 0);
    check("rst_ovf", acc_ovf, 0);
    check("rst_drop", drop_err, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);

    // Frame of 1..8 back to back.
    for (int i = 1; i <= COUNT; i++) begin
      step(1, i, 0);
      if (i < COUNT) check("t1_busy", busy, 1);
    end
    check("t1_valid", acc_valid, 1);
    check("t1_sum", acc_out, 36);
    check("t1_ovf", acc_ovf, 0);

    // Handshake cycle carries the first product of the next frame.
    step(1, 5, 1);
    for (int i = 0; i < COUNT - 1; i++) step(1, 1, 0);
    check("t3_sum", acc_out, 12);
    check("t3_drop", drop_err, 0);
    step(0, 0, 1);

    // Gapped products, then backpressure with a dropped product.
    for (int i = 0; i < COUNT; i++) begin
      step(1, 100, 0);
      step(0, 0, 0);
    end
    for (int i = 0; i < 3; i++) begin
      check("t2_hold", acc_out, 800);
      step(i == 1, 7, 0);
    end
    check("t2_drop", drop_err, 1);
    step(0, 0, 1);

    // Clear mid-frame with a simultaneous product.
    step(0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(1, 50, 0);
    step(1, 50, 0, 1);
    for (int i = 0; i < COUNT; i++) step(1, 2, 0);
    check("t4_sum", acc_out, 16);
    check("t4_drop", drop_err, 0);
    step(0, 0, 1);

    // Overflow frame, then a clean frame.
    for (int i = 0; i < COUNT; i++) step(1, 3969, 0);
`ifdef SATURATE_EN
    exp_ovf_out = 16383;
`else
    exp_ovf_out = 15368;
`endif
    check("t5_sum", acc_out, exp_ovf_out);
    check("t5_ovf", acc_ovf, 1);
    step(0, 0, 1);
    for (int i = 0; i < COUNT; i++) step(1, 1, 0);
    check("t5_next_sum", acc_out, 8);
    check("t5_next_ovf", acc_ovf, 0);

    // Reset while holding a result.
    step(0, 0, 0, 0, 0);
    check("t6_valid", acc_valid, 0);
    check("t6_out", acc_out, 0);
    check("t6_in_ready", in_ready, 1);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      bit pv, ar, cl, rs;
      int p;
      pv = ($urandom_range(0, 3) != 0);
      ar = $urandom_range(0, 1);
      cl = ($urandom_range(0, 63) == 0);
      rs = ($urandom_range(0, 255) != 0);
      p  = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 8191) : $urandom_range(0, 15);
      step(pv, p, ar, cl, rs);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
